// File: rtl/vga_sync.sv
// 640x480@60 VGA timing generator: pixel counters, registered active-low syncs, video_on and ticks.
// Optional macro VGA_SYNC_PIXEL_DIV_EN divides the 50 MHz clk by two to make a 25 MHz pixel enable.
module vga_sync #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HB = 48,
  parameter int HR = 96,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VB = 33,
  parameter int VR = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick
);

  localparam logic [9:0] H_MAX    = 10'(HD + HF + HB + HR - 1);
  localparam logic [9:0] V_MAX    = 10'(VD + VF + VB + VR - 1);
  localparam logic [9:0] HS_START = 10'(HD + HF);
  localparam logic [9:0] HS_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_START = 10'(VD + VF);
  localparam logic [9:0] VS_END   = 10'(VD + VF + VR - 1);
  localparam logic [9:0] H_DISP   = 10'(HD);
  localparam logic [9:0] V_DISP   = 10'(VD);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       tick;

`ifdef VGA_SYNC_PIXEL_DIV_EN
  logic div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= 1'b0;
    else       div_q <= ~div_q;
  end

  assign tick = div_q;
`else
  // Enable is permanently on outside reset; held low during reset so p_tick shows its reset value.
  assign tick = ~reset;
`endif

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) v_d = '0;
        else              v_d = v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Syncs decode the next-state counters so the registered pulse lines up with hcount/vcount.
    hs_d = ~((h_d >= HS_START) && (h_d <= HS_END));
    vs_d = ~((v_d >= VS_START) && (v_d <= VS_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign hcount     = h_q;
  assign vcount     = v_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign video_on   = (h_q < H_DISP) && (v_q < V_DISP);
  assign p_tick     = tick;
  assign frame_tick = tick && (h_q == H_MAX) && (v_q == V_MAX);

endmodule
